// File: rtl/issue_queue_if.sv
// Decode-side push and dispatcher-side issue signals of the issue queue.
// The master modport is the queue itself; the slave is decode plus dispatcher.
interface issue_queue_if #(
  parameter int DATA_W = 256
);
  logic              in_valid0;
  logic              in_valid1;
  logic [DATA_W-1:0] in_data0;
  logic [DATA_W-1:0] in_data1;
  logic              in_ready;
  logic              out_valid0;
  logic              out_valid1;
  logic [DATA_W-1:0] out_data0;
  logic [DATA_W-1:0] out_data1;
  logic              iss0;
  logic              iss1;

  modport master (
    input  in_valid0, in_valid1, in_data0, in_data1, iss0, iss1,
    output in_ready, out_valid0, out_valid1, out_data0, out_data1
  );

  modport slave (
    output in_valid0, in_valid1, in_data0, in_data1, iss0, iss1,
    input  in_ready, out_valid0, out_valid1, out_data0, out_data1
  );
endinterface

// File: rtl/issue_queue.sv
// Dual-push / dual-pop circular issue queue between decode and dispatch.
// Optional macro ASSERT_EN adds the sticky err flag and the dual_cnt counter.
module issue_queue #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 256,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          stall,
  issue_queue_if.master bus,
`ifdef ASSERT_EN
  output logic          err,
  output logic [31:0]   dual_cnt,
`endif
  output logic [CW-1:0] count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     head, tail;
  logic [PW-1:0]     head1, tail1;
  logic [1:0]        npush, npop;
  logic              pop0, pop1;
  logic [CW-1:0]     count_next;

  assign head1 = head + PW'(1);
  assign tail1 = tail + PW'(1);

  assign bus.in_ready   = (count <= CW'(DEPTH - 2));
  assign bus.out_valid0 = (count >= CW'(1));
  assign bus.out_valid1 = (count >= CW'(2));
  assign bus.out_data0  = mem[head];
  assign bus.out_data1  = mem[head1];

  // A lone in_valid1 or iss1 breaks ordering and is treated as no request.
  always_comb begin
    npush = 2'd0;
    if (bus.in_ready && bus.in_valid0)
      npush = bus.in_valid1 ? 2'd2 : 2'd1;
    pop0 = bus.iss0 & bus.out_valid0;
    pop1 = bus.iss0 & bus.iss1 & bus.out_valid1;
    npop = 2'd0;
    if (!stall)
      npop = {1'b0, pop0} + {1'b0, pop1};
    count_next = count + CW'(npush) - CW'(npop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(npop);
      tail  <= tail + PW'(npush);
      count <= count_next;
    end
  end

  // Payload storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!flush && npush != 2'd0) begin
      mem[tail] <= bus.in_data0;
      if (npush == 2'd2)
        mem[tail1] <= bus.in_data1;
    end
  end

`ifdef ASSERT_EN
  logic violation;

  assign violation = (bus.iss1 & ~bus.iss0 & ~stall)
                   | (bus.iss0 & ~bus.out_valid0)
                   | (bus.iss1 & ~bus.out_valid1)
                   | (bus.in_valid0 & ~bus.in_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err      <= 1'b0;
      dual_cnt <= '0;
    end else begin
      if (violation)
        err <= 1'b1;
      if (!flush && npop == 2'd2)
        dual_cnt <= dual_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_issue_queue.sv
// Directed self-checking bench for issue_queue with DEPTH=8, DATA_W=256.
// Extra checks on err and dual_cnt are compiled in when ASSERT_EN is defined.
module tb_issue_queue;
  localparam int DEPTH  = 8;
  localparam int DATA_W = 256;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          stall = 1'b0;
  logic [CW-1:0] count;
`ifdef ASSERT_EN
  logic          err;
  logic [31:0]   dual_cnt;
`endif

  int tests = 0;
  int fails = 0;

  issue_queue_if #(.DATA_W(DATA_W)) bus ();

  issue_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .stall    (stall),
    .bus      (bus.master),
`ifdef ASSERT_EN
    .err      (err),
    .dual_cnt (dual_cnt),
`endif
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [DATA_W-1:0] obs,
                              input logic [DATA_W-1:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic apply_stimulus(input logic v0, input logic v1, input int d0, input int d1,
                                input logic i0, input logic i1, input logic st, input logic fl);
    bus.in_valid0 = v0;
    bus.in_valid1 = v1;
    bus.in_data0  = DATA_W'(d0);
    bus.in_data1  = DATA_W'(d1);
    bus.iss0      = i0;
    bus.iss1      = i1;
    stall         = st;
    flush         = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input int c, input logic rdy,
                             input logic v0, input logic v1);
    check_output({tag, ".count"},  DATA_W'(count),          DATA_W'(c));
    check_output({tag, ".ready"},  DATA_W'(bus.in_ready),   DATA_W'(rdy));
    check_output({tag, ".valid0"}, DATA_W'(bus.out_valid0), DATA_W'(v0));
    check_output({tag, ".valid1"}, DATA_W'(bus.out_valid1), DATA_W'(v1));
  endtask

  task automatic check_data(input string tag, input int d0, input int d1);
    check_output({tag, ".data0"}, bus.out_data0, DATA_W'(d0));
    check_output({tag, ".data1"}, bus.out_data1, DATA_W'(d1));
  endtask

  initial begin
    bus.in_valid0 = 1'b0;
    bus.in_valid1 = 1'b0;
    bus.in_data0  = '0;
    bus.in_data1  = '0;
    bus.iss0      = 1'b0;
    bus.iss1      = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_state("reset", 0, 1'b1, 1'b0, 1'b0);
`ifdef ASSERT_EN
    check_output("reset.err",      DATA_W'(err),      '0);
    check_output("reset.dual_cnt", DATA_W'(dual_cnt), '0);
`endif

    // Fill the queue: packets 1..8 over four dual pushes.
    apply_stimulus(1, 1, 1, 2, 0, 0, 0, 0);
    check_state("push12", 2, 1'b1, 1'b1, 1'b1);
    check_data("push12", 1, 2);
    apply_stimulus(1, 1, 3, 4, 0, 0, 0, 0);
    apply_stimulus(1, 1, 5, 6, 0, 0, 0, 0);
    check_state("push56", 6, 1'b1, 1'b1, 1'b1);
    apply_stimulus(1, 1, 7, 8, 0, 0, 0, 0);
    check_state("full", 8, 1'b0, 1'b1, 1'b1);
    check_data("full", 1, 2);
`ifdef ASSERT_EN
    check_output("full.err", DATA_W'(err), '0);
`endif

    // Single pop on a full queue; the concurrent push must be dropped.
    apply_stimulus(1, 1, 99, 98, 1, 0, 0, 0);
    check_state("pop1", 7, 1'b0, 1'b1, 1'b1);
    check_data("pop1", 2, 3);
`ifdef ASSERT_EN
    check_output("drop.err", DATA_W'(err), 256'd1);
`endif

    apply_stimulus(0, 0, 0, 0, 1, 1, 0, 0);
    check_state("pop2a", 5, 1'b1, 1'b1, 1'b1);
    check_data("pop2a", 4, 5);
    apply_stimulus(0, 0, 0, 0, 1, 1, 0, 0);
    check_data("pop2b", 6, 7);
    apply_stimulus(0, 0, 0, 0, 1, 0, 0, 0);
    check_state("cnt2", 2, 1'b1, 1'b1, 1'b1);
    check_data("cnt2", 7, 8);

    // Dual push and dual pop in the same cycle.
    apply_stimulus(1, 1, 9, 10, 1, 1, 0, 0);
    check_state("pushpop", 2, 1'b1, 1'b1, 1'b1);
    check_data("pushpop", 9, 10);
`ifdef ASSERT_EN
    check_output("dual3", DATA_W'(dual_cnt), 256'd3);
`endif

    // Walk head to index 6, then leave the head pair straddling 7 -> 0.
    apply_stimulus(1, 1, 11, 12, 1, 1, 0, 0);
    apply_stimulus(1, 1, 13, 14, 1, 1, 0, 0);
    apply_stimulus(1, 1, 15, 16, 1, 1, 0, 0);
    check_data("head6", 15, 16);
    apply_stimulus(1, 1, 17, 18, 1, 0, 0, 0);
    check_state("wrap", 3, 1'b1, 1'b1, 1'b1);
    check_data("wrap", 16, 17);
    apply_stimulus(0, 0, 0, 0, 1, 1, 0, 0);
    check_state("wrappop", 1, 1'b1, 1'b1, 1'b0);
    check_output("wrappop.data0", bus.out_data0, 256'd18);

    // Stall freezes the read side even with both grants asserted.
    apply_stimulus(1, 1, 19, 20, 0, 0, 0, 0);
    apply_stimulus(1, 1, 21, 22, 0, 0, 0, 0);
    check_state("cnt5", 5, 1'b1, 1'b1, 1'b1);
    apply_stimulus(0, 0, 0, 0, 1, 1, 1, 0);
    check_state("stall", 5, 1'b1, 1'b1, 1'b1);
    check_data("stall", 18, 19);

    // Flush wins over stall, push and pop.
    apply_stimulus(1, 1, 23, 24, 1, 1, 1, 1);
    check_state("flush", 0, 1'b1, 1'b0, 1'b0);

    apply_stimulus(1, 0, 30, 31, 0, 0, 0, 0);
    check_state("single", 1, 1'b1, 1'b1, 1'b0);
    check_output("single.data0", bus.out_data0, 256'd30);
    apply_stimulus(0, 1, 40, 41, 0, 0, 0, 0);
    check_output("lone_v1.count", DATA_W'(count), 256'd1);
    apply_stimulus(0, 0, 0, 0, 0, 1, 0, 0);
    check_output("lone_iss1.count", DATA_W'(count), 256'd1);
    check_output("lone_iss1.data0", bus.out_data0, 256'd30);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef ASSERT_EN
    check_output("err_held",   DATA_W'(err),      256'd1);
    check_output("dual_final", DATA_W'(dual_cnt), 256'd7);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
